// File: rtl/cacheline_arbiter.sv
// rtl/cacheline_arbiter.sv - round-robin arbiter sharing one LLC cacheline port between I- and D-cache
module cacheline_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_read_i,
  input  logic              i_write_i,
  input  logic [ADDR_W-1:0] i_address_i,
  input  logic [LINE_W-1:0] i_line_i,
  output logic [LINE_W-1:0] i_line_o,
  output logic              i_resp_o,
  input  logic              d_read_i,
  input  logic              d_write_i,
  input  logic [ADDR_W-1:0] d_address_i,
  input  logic [LINE_W-1:0] d_line_i,
  output logic [LINE_W-1:0] d_line_o,
  output logic              d_resp_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_address_o,
  output logic [LINE_W-1:0] mem_line_o,
  input  logic [LINE_W-1:0] mem_line_i,
  input  logic              mem_resp_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  logic   owner_d;
  logic   pri_d;
  logic   i_act;
  logic   d_act;
  logic   grant_d;

  assign i_act   = i_read_i | i_write_i;
  assign d_act   = d_read_i | d_write_i;
  // D wins when it is the only requester or when the pointer favours it
  assign grant_d = d_act & (~i_act | pri_d);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      owner_d       <= 1'b0;
      pri_d         <= 1'b1;
      mem_read_o    <= 1'b0;
      mem_write_o   <= 1'b0;
      mem_address_o <= '0;
      mem_line_o    <= '0;
      i_line_o      <= '0;
      d_line_o      <= '0;
      i_resp_o      <= 1'b0;
      d_resp_o      <= 1'b0;
    end else begin
      i_resp_o <= 1'b0;
      d_resp_o <= 1'b0;
      case (state)
        IDLE: begin
          if (i_act | d_act) begin
            owner_d       <= grant_d;
            pri_d         <= ~grant_d;
            mem_address_o <= grant_d ? d_address_i : i_address_i;
            mem_line_o    <= grant_d ? d_line_i : i_line_i;
            mem_write_o   <= grant_d ? d_write_i : i_write_i;
            mem_read_o    <= grant_d ? ~d_write_i : ~i_write_i;
            state         <= BUSY;
          end
        end
        BUSY: begin
          if (mem_resp_i) begin
            mem_read_o  <= 1'b0;
            mem_write_o <= 1'b0;
            if (mem_read_o) begin
              if (owner_d) d_line_o <= mem_line_i;
              else         i_line_o <= mem_line_i;
            end
            if (owner_d) d_resp_o <= 1'b1;
            else         i_resp_o <= 1'b1;
            state <= RESP;
          end
        end
        RESP: begin
          // owner still holds its request this cycle; it must not restart a grant
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cacheline_arbiter.sv
// tb/tb_cacheline_arbiter.sv - self-checking bench for cacheline_arbiter
module tb_cacheline_arbiter;
  localparam int AW = 32;
  localparam int LW = 256;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          i_read_i, i_write_i, d_read_i, d_write_i, mem_resp_i;
  logic [AW-1:0] i_address_i, d_address_i, mem_address_o;
  logic [LW-1:0] i_line_i, d_line_i, mem_line_i;
  logic [LW-1:0] i_line_o, d_line_o, mem_line_o;
  logic          i_resp_o, d_resp_o, mem_read_o, mem_write_o;

  int total = 0;
  int bad   = 0;
  logic [LW-1:0] m_i_line, m_d_line;
  bit            favor_d;
  logic [LW-1:0] mem [logic [AW-1:0]];

  always #5 clk = ~clk;

  cacheline_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_read_i(i_read_i), .i_write_i(i_write_i), .i_address_i(i_address_i),
    .i_line_i(i_line_i), .i_line_o(i_line_o), .i_resp_o(i_resp_o),
    .d_read_i(d_read_i), .d_write_i(d_write_i), .d_address_i(d_address_i),
    .d_line_i(d_line_i), .d_line_o(d_line_o), .d_resp_o(d_resp_o),
    .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .mem_address_o(mem_address_o),
    .mem_line_o(mem_line_o), .mem_line_i(mem_line_i), .mem_resp_i(mem_resp_i)
  );

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [LW-1:0] fill(input logic [AW-1:0] a);
    return {8{a ^ 32'h5A5A_A5A5}};
  endfunction

  task automatic idle_inputs();
    i_read_i = 0; i_write_i = 0; i_address_i = '0; i_line_i = '0;
    d_read_i = 0; d_write_i = 0; d_address_i = '0; d_line_i = '0;
    mem_resp_i = 0; mem_line_i = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    @(negedge clk);
    reset_n = 0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1;
    m_i_line = '0; m_d_line = '0; favor_d = 1;
  endtask

  // Adaptor stand-in: waits for a request, holds it lat cycles, then responds once.
  task automatic serve(input int lat, input logic [LW-1:0] rdata, input bit perturb,
                       output bit ok, output bit stable, output logic [AW-1:0] a_seen,
                       output logic [LW-1:0] l_seen, output bit w_seen,
                       output int hi, output int ip, output int dp);
    int n;
    int waitc;
    ok = 0; stable = 1; waitc = 0; ip = 0; dp = 0; hi = 0;
    a_seen = '0; l_seen = '0; w_seen = 0;
    while (!(mem_read_o | mem_write_o) && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    if (mem_read_o | mem_write_o) begin
      ok = 1; a_seen = mem_address_o; l_seen = mem_line_o; w_seen = mem_write_o;
      n = 1;
      while (1) begin
        if (i_resp_o) ip++;
        if (d_resp_o) dp++;
        if (mem_address_o !== a_seen || mem_line_o !== l_seen ||
            mem_write_o !== w_seen || mem_read_o !== !w_seen) stable = 0;
        if (perturb && n == 2) begin
          d_address_i = ~d_address_i;
          d_line_i = ~d_line_i;
        end
        if (n >= lat) begin
          mem_line_i = rdata; mem_resp_i = 1;
          @(negedge clk);
          mem_resp_i = 0; mem_line_i = '0;
          if (i_resp_o) ip++;
          if (d_resp_o) dp++;
          break;
        end
        @(negedge clk);
        n++;
        if (!(mem_read_o | mem_write_o)) begin
          stable = 0;
          break;
        end
      end
      hi = n;
    end
  endtask

  task automatic test_reset();
    reset_n = 1;
    idle_inputs();
    #2 reset_n = 0;
    #1;
    total++; if (mem_read_o !== 0) begin bad++; $display("FAIL reset_mem_read: got=%0b want=0", mem_read_o); end
    total++; if (mem_write_o !== 0) begin bad++; $display("FAIL reset_mem_write: got=%0b want=0", mem_write_o); end
    total++; if (mem_address_o !== '0) begin bad++; $display("FAIL reset_mem_address: got=%h want=0", mem_address_o); end
    total++; if (i_resp_o !== 0 || d_resp_o !== 0) begin bad++; $display("FAIL reset_resp: got=%0b%0b want=00", i_resp_o, d_resp_o); end
    total++; if (i_line_o !== '0 || d_line_o !== '0 || mem_line_o !== '0) begin bad++; $display("FAIL reset_lines: got nonzero want=0"); end
    @(negedge clk);
    @(negedge clk);
    reset_n = 1;
    m_i_line = '0; m_d_line = '0; favor_d = 1;
  endtask

  task automatic test_single_read();
    bit ok, st, w; int hi, ip, dp; logic [AW-1:0] a; logic [LW-1:0] l, rd;
    rd = {{63{4'hA}}, 4'h1};
    @(negedge clk);
    d_read_i = 1; d_address_i = 32'h0000_1000;
    serve(6, rd, 0, ok, st, a, l, w, hi, ip, dp);
    total++; if (!ok) begin bad++; $display("FAIL rd_grant_timeout: got=none want=grant"); end
    total++; if (hi != 6) begin bad++; $display("FAIL rd_high_cycles: got=%0d want=6", hi); end
    total++; if (a !== 32'h1000 || w !== 0) begin bad++; $display("FAIL rd_addr: got=%h w=%0b want=1000 w=0", a, w); end
    total++; if (mem_read_o !== 0) begin bad++; $display("FAIL rd_clear: got=%0b want=0", mem_read_o); end
    total++; if (dp != 1 || ip != 0 || d_resp_o !== 1) begin bad++; $display("FAIL rd_resp: got d=%0d i=%0d want d=1 i=0", dp, ip); end
    total++; if (d_line_o !== rd) begin bad++; $display("FAIL rd_line: got=%h want=%h", d_line_o, rd); end
    m_d_line = rd;
    @(negedge clk);
    d_read_i = 0;
    total++; if (d_resp_o !== 0 || i_resp_o !== 0) begin bad++; $display("FAIL rd_pulse_width: got d=%0b i=%0b want 0 0", d_resp_o, i_resp_o); end
    repeat (3) @(negedge clk);
    total++; if (mem_read_o !== 0 || d_resp_o !== 0 || d_line_o !== m_d_line) begin bad++; $display("FAIL rd_idle_after: got read=%0b resp=%0b", mem_read_o, d_resp_o); end
  endtask

  task automatic test_single_write();
    bit ok, st, w; int hi, ip, dp; logic [AW-1:0] a; logic [LW-1:0] l, data;
    data = {4{64'h0123_4567_89AB_CDEF}};
    @(negedge clk);
    i_write_i = 1; i_address_i = 32'h40; i_line_i = data;
    serve(4, rand_line(), 0, ok, st, a, l, w, hi, ip, dp);
    total++; if (!ok || w !== 1 || hi != 4) begin bad++; $display("FAIL wr_req: got ok=%0b w=%0b hi=%0d want 1 1 4", ok, w, hi); end
    total++; if (a !== 32'h40 || l !== data) begin bad++; $display("FAIL wr_latch: got a=%h l=%h", a, l); end
    total++; if (!st) begin bad++; $display("FAIL wr_stable: got=unstable want=stable"); end
    total++; if (ip != 1 || dp != 0 || i_resp_o !== 1) begin bad++; $display("FAIL wr_resp: got i=%0d d=%0d want i=1 d=0", ip, dp); end
    total++; if (i_line_o !== m_i_line) begin bad++; $display("FAIL wr_line_kept: got=%h want=%h", i_line_o, m_i_line); end
    total++; if (mem_write_o !== 0) begin bad++; $display("FAIL wr_clear: got=%0b want=0", mem_write_o); end
    @(negedge clk);
    i_write_i = 0;
  endtask

  task automatic test_back_to_back();
    bit ok, st, w, exp_d; int hi, ip, dp; logic [AW-1:0] a, ea; logic [LW-1:0] l, rd;
    apply_reset();
    @(negedge clk);
    i_read_i = 1; i_address_i = 32'h2000;
    d_read_i = 1; d_address_i = 32'h3000;
    for (int t = 0; t < 4; t++) begin
      exp_d = (t % 2 == 0);
      ea = exp_d ? 32'h3000 : 32'h2000;
      rd = rand_line();
      serve(int'($urandom_range(1, 5)), rd, 0, ok, st, a, l, w, hi, ip, dp);
      total++; if (!ok || a !== ea) begin bad++; $display("FAIL b2b_order[%0d]: got=%h want=%h", t, a, ea); end
      total++;
      if (exp_d ? (d_resp_o !== 1 || i_resp_o !== 0 || d_line_o !== rd)
                : (i_resp_o !== 1 || d_resp_o !== 0 || i_line_o !== rd)) begin
        bad++; $display("FAIL b2b_resp[%0d]: got i=%0b d=%0b want owner_d=%0b", t, i_resp_o, d_resp_o, exp_d);
      end
      if (exp_d) m_d_line = rd; else m_i_line = rd;
    end
    @(negedge clk);
    i_read_i = 0; d_read_i = 0;
  endtask

  task automatic test_mid_change();
    bit ok, st, w; int hi, ip, dp; logic [AW-1:0] a; logic [LW-1:0] l, data;
    data = rand_line();
    @(negedge clk);
    d_write_i = 1; d_address_i = 32'h0000_7000; d_line_i = data;
    serve(5, rand_line(), 1, ok, st, a, l, w, hi, ip, dp);
    total++; if (!ok || !st) begin bad++; $display("FAIL mid_stable: got ok=%0b stable=%0b want 1 1", ok, st); end
    total++; if (a !== 32'h7000 || l !== data) begin bad++; $display("FAIL mid_latch: got a=%h want=7000", a); end
    total++; if (d_line_o !== m_d_line || d_resp_o !== 1) begin bad++; $display("FAIL mid_resp: got resp=%0b", d_resp_o); end
    @(negedge clk);
    d_write_i = 0;
  endtask

  task automatic test_reset_mid();
    bit ok, st, w; int hi, ip, dp; logic [AW-1:0] a; logic [LW-1:0] l, rd;
    @(negedge clk);
    d_read_i = 1; d_address_i = 32'h5000;
    @(negedge clk);
    @(negedge clk);
    total++; if (mem_read_o !== 1) begin bad++; $display("FAIL rst_mid_busy: got=%0b want=1", mem_read_o); end
    i_read_i = 1; i_address_i = 32'h6000;
    #1 reset_n = 0;
    #1;
    total++;
    if (mem_read_o !== 0 || mem_write_o !== 0 || mem_address_o !== '0 || mem_line_o !== '0 ||
        i_line_o !== '0 || d_line_o !== '0 || i_resp_o !== 0 || d_resp_o !== 0) begin
      bad++; $display("FAIL rst_mid_async: got read=%0b addr=%h want all 0", mem_read_o, mem_address_o);
    end
    m_i_line = '0; m_d_line = '0; favor_d = 1;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1;
    rd = rand_line();
    serve(3, rd, 0, ok, st, a, l, w, hi, ip, dp);
    total++; if (!ok || a !== 32'h5000 || d_resp_o !== 1) begin bad++; $display("FAIL rst_mid_first: got=%h want=5000", a); end
    m_d_line = rd;
    @(negedge clk);
    d_read_i = 0;
    rd = rand_line();
    serve(2, rd, 0, ok, st, a, l, w, hi, ip, dp);
    total++; if (!ok || a !== 32'h6000 || i_resp_o !== 1 || i_line_o !== rd) begin bad++; $display("FAIL rst_mid_second: got=%h want=6000", a); end
    m_i_line = rd;
    @(negedge clk);
    i_read_i = 0;
  endtask

  task automatic test_stray();
    bit ok, st, w; int hi, ip, dp; logic [AW-1:0] a; logic [LW-1:0] l, rd;
    @(negedge clk);
    mem_resp_i = 1; mem_line_i = rand_line();
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      total++;
      if (i_resp_o !== 0 || d_resp_o !== 0 || mem_read_o !== 0 || mem_write_o !== 0 ||
          i_line_o !== m_i_line || d_line_o !== m_d_line) begin
        bad++; $display("FAIL stray[%0d]: got resp i=%0b d=%0b read=%0b", t, i_resp_o, d_resp_o, mem_read_o);
      end
    end
    mem_resp_i = 0; mem_line_i = '0;
    d_read_i = 1; d_address_i = 32'h9000;
    rd = rand_line();
    serve(2, rd, 0, ok, st, a, l, w, hi, ip, dp);
    total++; if (!ok || a !== 32'h9000 || dp != 1 || d_line_o !== rd) begin bad++; $display("FAIL stray_after: got a=%h dp=%0d", a, dp); end
    m_d_line = rd;
    @(negedge clk);
    d_read_i = 0;
  endtask

  task automatic test_random(input int cycles);
    bit i_on, d_on, i_wr, d_wr, i_rd, d_rd, ri, rdq, busy, resp_due;
    bit g_wr, g_d, prev_mreq, exp_grant, obs_grant, mreq;
    int i_gap, d_gap, i_drop, d_drop, n, lat, free_from;
    logic [AW-1:0] g_addr;
    logic [LW-1:0] g_line, exp_rdata;
    apply_reset();
    mem.delete();
    i_on = 0; d_on = 0; i_wr = 0; d_wr = 0; i_rd = 0; d_rd = 0; ri = 0; rdq = 0;
    busy = 0; resp_due = 0; g_wr = 0; g_d = 0; prev_mreq = 0;
    i_gap = 0; d_gap = 0; i_drop = -1; d_drop = -1; n = 0; lat = 1; free_from = 0;
    g_addr = '0; g_line = '0; exp_rdata = '0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      mreq = mem_read_o | mem_write_o;
      mem_resp_i = 0;
      if (resp_due) begin
        total++;
        if (mreq !== 0 || (g_d ? (d_resp_o !== 1 || i_resp_o !== 0) : (i_resp_o !== 1 || d_resp_o !== 0))) begin
          bad++; $display("FAIL rnd_resp c=%0d: got req=%0b i=%0b d=%0b want owner_d=%0b", c, mreq, i_resp_o, d_resp_o, g_d);
        end
        if (!g_wr) begin
          if (g_d) m_d_line = exp_rdata; else m_i_line = exp_rdata;
        end
        if (g_d) d_drop = c + 1; else i_drop = c + 1;
        resp_due = 0; busy = 0; free_from = c + 2;
      end else begin
        total++;
        if (i_resp_o !== 0 || d_resp_o !== 0) begin bad++; $display("FAIL rnd_noresp c=%0d: got i=%0b d=%0b want 0 0", c, i_resp_o, d_resp_o); end
      end
      total++;
      if (i_line_o !== m_i_line || d_line_o !== m_d_line) begin bad++; $display("FAIL rnd_line c=%0d: got i=%h want=%h", c, i_line_o, m_i_line); end
      exp_grant = !busy && c >= free_from && (ri || rdq);
      obs_grant = mreq && !prev_mreq;
      total++;
      if (obs_grant !== exp_grant) begin bad++; $display("FAIL rnd_grant c=%0d: got=%0b want=%0b", c, obs_grant, exp_grant); end
      if (exp_grant) begin
        g_d = rdq && (!ri || favor_d);
        favor_d = !g_d;
        g_wr = g_d ? d_wr : i_wr;
        g_addr = g_d ? d_address_i : i_address_i;
        g_line = g_d ? d_line_i : i_line_i;
        busy = 1; n = 0; lat = int'($urandom_range(1, 6));
      end
      if (busy) begin
        n++;
        total++;
        if (mem_read_o !== !g_wr || mem_write_o !== g_wr || mem_address_o !== g_addr || mem_line_o !== g_line) begin
          bad++; $display("FAIL rnd_mem c=%0d: got addr=%h wr=%0b want addr=%h wr=%0b", c, mem_address_o, mem_write_o, g_addr, g_wr);
        end
        if (n == lat) begin
          if (g_wr) begin
            mem[g_addr] = g_line;
            mem_line_i = rand_line();
          end else begin
            exp_rdata = mem.exists(g_addr) ? mem[g_addr] : fill(g_addr);
            mem_line_i = exp_rdata;
          end
          mem_resp_i = 1; resp_due = 1;
        end
      end else if ($urandom_range(0, 7) == 0) begin
        mem_resp_i = 1; mem_line_i = rand_line();
      end
      if (i_on && c == i_drop) begin
        i_on = 0; i_gap = int'($urandom_range(0, 3));
      end else if (!i_on) begin
        if (i_gap > 0) i_gap--;
        else if ($urandom_range(0, 2) != 0) begin
          i_on = 1; i_wr = 1'($urandom_range(0, 1)); i_rd = !i_wr || ($urandom_range(0, 1) == 1);
          i_address_i = 32'($urandom_range(0, 3) << 6); i_line_i = rand_line();
        end
      end
      if (d_on && c == d_drop) begin
        d_on = 0; d_gap = int'($urandom_range(0, 3));
      end else if (!d_on) begin
        if (d_gap > 0) d_gap--;
        else if ($urandom_range(0, 2) != 0) begin
          d_on = 1; d_wr = 1'($urandom_range(0, 1)); d_rd = !d_wr || ($urandom_range(0, 1) == 1);
          d_address_i = 32'h8000_0000 | 32'($urandom_range(0, 3) << 6); d_line_i = rand_line();
        end
      end
      i_read_i = i_on & i_rd; i_write_i = i_on & i_wr;
      d_read_i = d_on & d_rd; d_write_i = d_on & d_wr;
      ri = i_on; rdq = d_on; prev_mreq = mreq;
    end
    idle_inputs();
  endtask

  initial begin
    reset_n = 1;
    m_i_line = '0; m_d_line = '0; favor_d = 1;
    idle_inputs();
    test_reset();
    test_single_read();
    test_single_write();
    test_back_to_back();
    test_mid_change();
    test_reset_mid();
    test_stray();
    test_random(3000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
